// File: rtl/mem_read_d_if.sv
// Bundle for the D drain stage: start/count control, BRAM read port and output stream.
// The master side is the surrounding system (BRAM banks and consumer); the slave side is the drain engine.
interface mem_read_d_if #(
  parameter int D_W          = 32,
  parameter int N1           = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int ADDR_W       = 12
);
  logic                          start;
  logic [MATRIXSIZE_W-1:0]       M1xM3dN1;
  logic [N1-1:0][ADDR_W-1:0]     rd_addr_bram;
  logic [N1-1:0]                 rd_en_bram;
  logic [N1-1:0][D_W-1:0]        rd_data_bram;
  logic signed [D_W-1:0]         out_data;
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_last;
  logic                          busy;
  logic                          done;

  modport master (
    output start, M1xM3dN1, rd_data_bram, out_ready,
    input  rd_addr_bram, rd_en_bram, out_data, out_valid, out_last, busy, done
  );

  modport slave (
    input  start, M1xM3dN1, rd_data_bram, out_ready,
    output rd_addr_bram, rd_en_bram, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/mem_read_d.sv
// Drains N1 lockstep BRAM banks row by row into one valid/ready stream, lane 0 first.
// A credit counter caps in-flight reads plus buffered rows at the row FIFO depth.
module mem_read_d_lane #(
  parameter int D_W = 32,
  parameter int FD  = 4,
  parameter int PW  = 2
) (
  input  logic           clk,
  input  logic           i_we,
  input  logic [PW-1:0]  i_wp,
  input  logic [D_W-1:0] i_wd,
  input  logic [PW-1:0]  i_rp,
  output logic [D_W-1:0] o_rd
);
  logic [D_W-1:0] r_mem [FD];

  always_ff @(posedge clk)
    if (i_we) r_mem[i_wp] <= i_wd;

  assign o_rd = r_mem[i_rp];
endmodule

module mem_read_d #(
  parameter int D_W          = 32,
  parameter int N1           = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int ADDR_W       = 12,
  parameter int RD_LAT       = 2
) (
  input  logic         clk,
  input  logic         rst,
  mem_read_d_if.slave  bus
);
  localparam int LIM = RD_LAT + 2;
  localparam int PW  = $clog2(LIM);
  localparam int CW  = $clog2(LIM + 1);
  localparam int LW  = (N1 > 1) ? $clog2(N1) : 1;
  localparam int BW  = MATRIXSIZE_W + $clog2(N1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                  r_state, w_state_nxt;
  logic [MATRIXSIZE_W-1:0] r_count, r_addr;
  logic [CW-1:0]           r_credits, r_fcnt;
  logic [RD_LAT:1]         r_vld_pipe;
  logic [PW-1:0]           r_wp, r_rp;
  logic [LW-1:0]           r_lane;
  logic [BW-1:0]           r_beat, w_total;
  logic                    r_done;
  logic                    w_issue, w_start_ok, w_done_nxt;
  logic                    w_valid, w_hs, w_pop, w_last, w_we;
  logic [N1-1:0][D_W-1:0]  w_row;

  assign w_valid = (r_fcnt != '0);
  assign w_hs    = w_valid & bus.out_ready;
  assign w_pop   = w_hs && (r_lane == LW'(N1 - 1));
  assign w_total = BW'(r_count) * BW'(N1);
  assign w_last  = w_valid && (r_beat == w_total - BW'(1));
  assign w_we    = r_vld_pipe[RD_LAT];

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_start_ok  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE:
        if (bus.start) begin
          if (bus.M1xM3dN1 != '0) begin
            w_start_ok  = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      S_RUN:
        // Issue only while a FIFO slot is guaranteed for the returning row.
        if (r_credits < CW'(LIM)) begin
          w_issue = 1'b1;
          if (r_addr == r_count - MATRIXSIZE_W'(1)) w_state_nxt = S_DRAIN;
        end
      S_DRAIN:
        if (w_hs && w_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_count    <= '0;
      r_addr     <= '0;
      r_credits  <= '0;
      r_vld_pipe <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_fcnt     <= '0;
      r_lane     <= '0;
      r_beat     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_done        <= w_done_nxt;
      r_vld_pipe[1] <= w_issue;
      for (int i = 2; i <= RD_LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];

      if (w_issue) r_addr <= r_addr + MATRIXSIZE_W'(1);

      case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits + CW'(1);
        2'b01:   r_credits <= r_credits - CW'(1);
        default: ;
      endcase

      if (w_we) r_wp <= (r_wp == PW'(LIM - 1)) ? '0 : r_wp + PW'(1);
      if (w_pop) r_rp <= (r_rp == PW'(LIM - 1)) ? '0 : r_rp + PW'(1);
      case ({w_we, w_pop})
        2'b10:   r_fcnt <= r_fcnt + CW'(1);
        2'b01:   r_fcnt <= r_fcnt - CW'(1);
        default: ;
      endcase

      if (w_hs) begin
        r_lane <= w_pop ? '0 : r_lane + LW'(1);
        r_beat <= r_beat + BW'(1);
      end

      if (w_start_ok) begin
        r_count <= bus.M1xM3dN1;
        r_addr  <= '0;
        r_beat  <= '0;
      end
    end
  end

  for (genvar g = 0; g < N1; g++) begin : g_lane
    mem_read_d_lane #(.D_W(D_W), .FD(LIM), .PW(PW)) u_lane (
      .clk  (clk),
      .i_we (w_we),
      .i_wp (r_wp),
      .i_wd (bus.rd_data_bram[g]),
      .i_rp (r_rp),
      .o_rd (w_row[g])
    );
    assign bus.rd_addr_bram[g] = ADDR_W'(r_addr);
  end

  assign bus.rd_en_bram = {N1{w_issue}};
  // Gated so the stream reads 0 whenever nothing is buffered, including right after reset.
  assign bus.out_data   = w_valid ? w_row[r_lane] : '0;
  assign bus.out_valid  = w_valid;
  assign bus.out_last   = w_last;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = r_done;
endmodule

// File: tb/tb_mem_read_d.sv
// Directed bench for mem_read_d: bank b, address a holds a*16+b; checks order, last flag, latency, credits.
module tb_mem_read_d;
  localparam int D_W = 32, N1 = 4, MW = 16, AW = 12, RL = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_read_d_if #(.D_W(D_W), .N1(N1), .MATRIXSIZE_W(MW), .ADDR_W(AW)) bus ();

  mem_read_d #(.D_W(D_W), .N1(N1), .MATRIXSIZE_W(MW), .ADDR_W(AW), .RD_LAT(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // BRAM model: RL register stages, contents a*16+b
  logic [N1-1:0][D_W-1:0] bq [RL];
  always @(posedge clk) begin
    for (int s = RL - 1; s > 0; s--) bq[s] <= bq[s-1];
    for (int b = 0; b < N1; b++) bq[0][b] <= D_W'(int'(bus.rd_addr_bram[b]) * 16 + b);
  end
  assign bus.rd_data_bram = bq[RL-1];

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ready driver: 0 = hold low, 1 = hold high, 2 = random
  int rmode = 1;
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rmode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  int ncyc = 0, e_cyc = 0;
  int n_rd, n_valid, n_done, first_rd, first_vld, done_cyc, last_hs, max_out, pops;
  int got[$];
  bit lastq[$];
  int addrs[$];
  logic prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
  logic [D_W-1:0] prev_d = '0;

  task automatic clr_log();
    n_rd = 0; n_valid = 0; n_done = 0; first_rd = -1; first_vld = -1;
    done_cyc = -1; last_hs = -1; max_out = 0; pops = 0;
    got.delete(); lastq.delete(); addrs.delete();
  endtask

  initial forever begin
    @(negedge clk);
    ncyc++;
    if (!rst) begin
      prev_v = 1'b0;
      continue;
    end
    if (bus.rd_en_bram != '0) begin
      n_rd++;
      addrs.push_back(int'(bus.rd_addr_bram[0]));
      if (first_rd < 0) first_rd = ncyc;
    end
    if (bus.out_valid) begin
      n_valid++;
      if (first_vld < 0) first_vld = ncyc;
      if (prev_v && !prev_r) begin
        chk("stall_data", bus.out_data, signed'(prev_d));
        chk("stall_last", bus.out_last, prev_l);
      end
      if (bus.out_ready) begin
        got.push_back(int'(bus.out_data));
        lastq.push_back(bus.out_last);
        if (bus.out_last) last_hs = ncyc;
        if (got.size() % N1 == 0) pops++;
      end
    end
    if (n_rd - pops > max_out) max_out = n_rd - pops;
    if (bus.done) begin
      n_done++;
      if (done_cyc < 0) done_cyc = ncyc;
    end
    prev_v = bus.out_valid; prev_r = bus.out_ready;
    prev_d = bus.out_data;  prev_l = bus.out_last;
  end

  task automatic do_start(input int cnt);
    @(posedge clk); #1;
    bus.M1xM3dN1 = MW'(cnt);
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    e_cyc     = ncyc;
  endtask

  task automatic wait_done(input int maxc);
    int k = 0;
    while (done_cyc < 0 && k < maxc) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_seen", done_cyc >= 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_seq(input string tag, input int rows);
    int nl = 0;
    chk({tag, "_len"}, got.size(), rows * N1);
    for (int i = 0; i < got.size() && i < rows * N1; i++) begin
      chk($sformatf("%s_beat%0d", tag, i), got[i], (i / N1) * 16 + i % N1);
      if (lastq[i]) nl++;
    end
    chk({tag, "_nlast"}, nl, 1);
    if (got.size() > 0) chk({tag, "_lastpos"}, lastq[got.size()-1], 1);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_en"},   bus.rd_en_bram, 0);
    chk({tag, "_addr"}, bus.rd_addr_bram, 0);
    chk({tag, "_vld"},  bus.out_valid, 0);
    chk({tag, "_data"}, bus.out_data, 0);
    chk({tag, "_last"}, bus.out_last, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.M1xM3dN1 = '0;
    clr_log();
    #2;
    chk_rst("rst");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // nominal drain
    rmode = 1;
    clr_log();
    do_start(3);
    chk("s1_busy", bus.busy, 1);
    wait_done(100);
    chk_seq("s1", 3);
    chk("s1_nrd", n_rd, 3);
    chk("s1_first_rd", first_rd, e_cyc + 1);
    chk("s1_first_vld", first_vld, e_cyc + 2 + RL);
    chk("s1_done_lat", done_cyc, last_hs + 1);
    chk("s1_ndone", n_done, 1);
    chk("s1_busy_end", bus.busy, 0);

    // random backpressure
    rmode = 2;
    clr_log();
    do_start(3);
    wait_done(400);
    chk_seq("s2", 3);
    chk("s2_credit_max", max_out <= RL + 2, 1);
    chk("s2_nrd", n_rd, 3);

    // zero count
    rmode = 1;
    clr_log();
    do_start(0);
    repeat (6) @(posedge clk);
    #1;
    chk("s3_done_cyc", done_cyc, e_cyc + 1);
    chk("s3_ndone", n_done, 1);
    chk("s3_nrd", n_rd, 0);
    chk("s3_nvld", n_valid, 0);

    // start while busy is ignored
    clr_log();
    do_start(3);
    repeat (2) @(posedge clk);
    #1 bus.M1xM3dN1 = MW'(7); bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(100);
    chk_seq("s4a", 3);
    chk("s4a_nrd", n_rd, 3);
    clr_log();
    do_start(3);
    wait_done(100);
    chk_seq("s4b", 3);
    chk("s4b_addr0", addrs.size() > 0 ? addrs[0] : -1, 0);

    // reset mid-burst
    clr_log();
    do_start(3);
    for (int k = 0; k < 50 && got.size() < 5; k++) begin
      @(posedge clk); #1;
    end
    chk("s5_reach5", got.size() >= 5, 1);
    rst = 1'b0;
    #1;
    chk_rst("s5_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    clr_log();
    repeat (10) @(posedge clk);
    #1;
    chk("s5_quiet_vld", n_valid, 0);
    chk("s5_quiet_rd", n_rd, 0);
    clr_log();
    do_start(3);
    wait_done(100);
    chk_seq("s5", 3);
    chk("s5_addr0", addrs.size() > 0 ? addrs[0] : -1, 0);

    // credit limit under full stall
    rmode = 0;
    clr_log();
    do_start(6);
    repeat (20) @(posedge clk);
    #1;
    chk("s6_stall_nrd", n_rd, RL + 2);
    chk("s6_addr3", addrs.size() > 3 ? addrs[3] : -1, 3);
    chk("s6_nbeats", got.size(), 0);
    rmode = 1;
    wait_done(200);
    chk_seq("s6", 6);
    chk("s6_nrd", n_rd, 6);
    chk("s6_credit_max", max_out <= RL + 2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_read_d.md
# mem_read_D

Drains the D result matrix from the N1 per-lane BRAM banks filled by the D write stage and serialises it into a single valid/ready stream for the downstream consumer. On a `start` pulse it reads addresses 0..M1xM3dN1-1 from all banks in lockstep and buffers the returned row vectors. It emits each row lane 0 first, lane N1-1 last, and flags the final beat. A credit counter bounds in-flight reads so that backpressure never drops or duplicates data.

## Interface
- `D_W`, 32: data word width.
- `N1`, 4: number of lanes and banks, which is also the number of beats per row.
- `MATRIXSIZE_W`, 16: width of the row-count input.
- `ADDR_W`, 12: BRAM address width.
- `RD_LAT`, 2: BRAM read latency in cycles, at least 1.
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a drain; ignored while `busy`=1.
- `M1xM3dN1`  in  MATRIXSIZE_W  rows per bank; sampled on the `start` edge.
- `rd_addr_bram[N1]`  out  ADDR_W each  read address, identical across banks.
- `rd_en_bram`  out  N1  read enable, all bits equal.
- `rd_data_bram[N1]`  in  signed D_W each  bank read data, valid RD_LAT cycles after `rd_en_bram`.
- `out_data`  out  signed D_W  stream data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.
- `out_last`  out  1  high on the final beat of the drain.
- `busy`  out  1  high from the cycle after the accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.

## Operation
- **FSM states: IDLE, RUN, DRAIN.**
  - IDLE, `start`=1, count≠0: latch the count, clear the address, enter RUN.
  - IDLE, `start`=1, count=0: pulse `done` next cycle and stay in IDLE.
  - RUN: issue a read (`rd_en_bram`=all ones) whenever credits < RD_LAT+2. The address increments after each issue. After issuing address count-1, enter DRAIN.
  - DRAIN: wait for the last beat handshake, then go to IDLE, asserting `done` for one cycle in the following cycle.
- **In-flight tracking.** An RD_LAT-deep valid shift register tracks issued reads. When its output is set, `rd_data_bram` for all N1 lanes is written as one row into a row FIFO of depth RD_LAT+2.
- **Credits.** Credits = in-flight reads + rows stored in the FIFO.
  - Increment on issue; decrement when the last lane of a row is accepted.
  - Credits never exceed RD_LAT+2, so the FIFO can never overflow.
- **Serialiser.**
  - Lane counter 0..N1-1 selects `out_data` from the FIFO head row.
  - `out_valid` = FIFO not empty.
  - The counter advances on the handshake (`out_valid`&`out_ready`). On the handshake at lane N1-1 it wraps to 0 and the head row pops.
- **Last beat.** A beat counter runs 0..count*N1-1, sized MATRIXSIZE_W+clog2(N1). `out_last` is high when the counter equals count*N1-1.
- **Stability.** While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
- **Width rules.** `rd_addr_bram` is the low ADDR_W bits of the row counter; counts above 2^ADDR_W are unsupported.

## Timing
- **Reset values (asserted asynchronously):** `rd_addr_bram` 0, `rd_en_bram` 0, `out_data` 0, `out_valid` 0, `out_last` 0, `busy` 0, `done` 0. Credits, FIFO, valid pipe and all counters are also cleared.
- **Latency, `start` accepted at edge E:**
  - First `rd_en_bram` is high in cycle E+1.
  - Row data is captured at the end of cycle E+1+RD_LAT.
  - First `out_valid` is high in cycle E+2+RD_LAT.
- **Throughput.** With `out_ready` held at 1 the stream sustains 1 beat/cycle with no bubbles after the first beat. Reads are issued at most once per cycle.
- **Stall.** With `out_ready`=0 indefinitely, exactly RD_LAT+2 reads are issued and then `rd_en_bram` stays 0.
- **Mid-operation reset.** In-flight BRAM data is discarded. After release no stale beat appears, and the next `start` restarts from address 0.

## Test plan
1. **Nominal drain.** N1=4, RD_LAT=2, count=3, bank b address a preloaded with a*16+b, `out_ready`=1.
   - 12 beats in the order 0,1,2,3,16,17,18,19,32..35.
   - `out_last` only on beat 12.
   - First `out_valid` at E+4; `done` one cycle after the last handshake.
2. **Random backpressure.** Same preload as scenario 1, `out_ready` random at 50% → identical sequence with no drops or duplicates. `out_data` is stable across every stall and credits never exceed 4.
3. **Zero count.** `start` with count=0 → `done` pulses at E+1, with no `rd_en_bram` and no `out_valid`.
4. **Start handling.**
   - `start` re-pulsed while `busy` → ignored, and the sequence is unchanged.
   - A second `start` after `done` → the full sequence repeats from address 0.
5. **Reset mid-burst.** `rst` low after beat 5 → every output is at its reset value within the same cycle. After release there is no output until a new `start`, which produces a correct full sequence.
6. **Credit limit.** `out_ready` held at 0 for 20 cycles after `start` → exactly 4 `rd_en_bram` pulses occur (addresses 0..3). Raising `out_ready` resumes issue and delivers the remaining beats correctly.
